// File: rtl/write_back_pkg.sv
// Shared opcode definitions and write-back helpers used by the execution and write-back stages.
package write_back_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned REG_W  = 8;

    // Opcode encodings; any value not listed here is undefined and retires nothing.
    localparam logic [OP_W-1:0] NOP   = 6'h00;
    localparam logic [OP_W-1:0] LDA   = 6'h01;
    localparam logic [OP_W-1:0] LDB   = 6'h02;
    localparam logic [OP_W-1:0] ADDA  = 6'h03;
    localparam logic [OP_W-1:0] ADDB  = 6'h04;
    localparam logic [OP_W-1:0] ADDCA = 6'h05;
    localparam logic [OP_W-1:0] ADDCB = 6'h06;
    localparam logic [OP_W-1:0] SUBA  = 6'h07;
    localparam logic [OP_W-1:0] SUBB  = 6'h08;
    localparam logic [OP_W-1:0] SUBCA = 6'h09;
    localparam logic [OP_W-1:0] SUBCB = 6'h0A;
    localparam logic [OP_W-1:0] ANDA  = 6'h0B;
    localparam logic [OP_W-1:0] ANDB  = 6'h0C;
    localparam logic [OP_W-1:0] ANDCA = 6'h0D;
    localparam logic [OP_W-1:0] ANDCB = 6'h0E;
    localparam logic [OP_W-1:0] ORA   = 6'h0F;
    localparam logic [OP_W-1:0] ORB   = 6'h10;
    localparam logic [OP_W-1:0] ORCA  = 6'h11;
    localparam logic [OP_W-1:0] ORCB  = 6'h12;
    localparam logic [OP_W-1:0] ASLA  = 6'h13;
    localparam logic [OP_W-1:0] ASRA  = 6'h14;

    // Which architectural register an opcode writes, and from which source.
    typedef enum logic [2:0] {
        WB_NONE,
        WB_A_ALU,
        WB_A_LD,
        WB_B_ALU,
        WB_B_LD
    } wb_target_e;

    // Register plus its carry flag, stored together in one enable flop.
    typedef struct packed {
        logic             carry;
        logic [REG_W-1:0] data;
    } reg_word_t;

    // Map an opcode to its write-back target; undefined opcodes fall to WB_NONE.
    function automatic wb_target_e decode_target(input logic [OP_W-1:0] op);
        wb_target_e tgt;
        tgt = WB_NONE;
        case (op)
            ADDA, ADDCA, SUBA, SUBCA, ANDA, ANDCA, ORA, ORCA, ASLA, ASRA: tgt = WB_A_ALU;
            ADDB, ADDCB, SUBB, SUBCB, ANDB, ANDCB, ORB, ORCB:             tgt = WB_B_ALU;
            LDA:                                                          tgt = WB_A_LD;
            LDB:                                                          tgt = WB_B_LD;
            default:                                                      tgt = WB_NONE;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/write_back_ffd.sv
// Enable flip-flop with synchronous active-high reset.
module write_back_ffd #(
    parameter int unsigned W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Reset wins over enable; otherwise load on enable, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/write_back.sv
// Write-back stage: retires opcodes into registers A/B and their carry flags, counts retirements.
module write_back
    import write_back_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [OP_W-1:0]    iOperation_EXC,
    input  logic [DATA_W-1:0]  iData_EXC,
    input  logic [REG_W-1:0]   iResult,
    input  logic               iCarry,
    input  logic               iStall,
    output logic [REG_W-1:0]   oReg_A,
    output logic [REG_W-1:0]   oReg_B,
    output logic               oCarryA,
    output logic               oCarryB,
    output logic               oZeroA,
    output logic               oZeroB,
    output logic [COUNT_W-1:0] oRetired
);

    wb_target_e         tgt_c;
    logic               en_a_c;
    logic               en_b_c;
    reg_word_t          a_d;
    reg_word_t          b_d;
    reg_word_t          a_q;
    reg_word_t          b_q;
    logic [COUNT_W-1:0] retired_d;
    logic [COUNT_W-1:0] retired_q;

    // Load immediates only carry eight bits; the upper immediate bits are not architectural here.
    logic unused_data_hi;
    assign unused_data_hi = ^iData_EXC[DATA_W-1:REG_W];

    // Decode the target register and next values; a stall suppresses every enable.
    always_comb begin
        tgt_c     = decode_target(iOperation_EXC);
        en_a_c    = 1'b0;
        en_b_c    = 1'b0;
        a_d       = '{carry: iCarry, data: iResult};
        b_d       = '{carry: iCarry, data: iResult};
        retired_d = retired_q;
        if (!iStall) begin
            case (tgt_c)
                WB_A_ALU: en_a_c = 1'b1;
                WB_A_LD: begin
                    en_a_c = 1'b1;
                    a_d    = '{carry: a_q.carry, data: iData_EXC[REG_W-1:0]};
                end
                WB_B_ALU: en_b_c = 1'b1;
                WB_B_LD: begin
                    en_b_c = 1'b1;
                    b_d    = '{carry: b_q.carry, data: iData_EXC[REG_W-1:0]};
                end
                default: begin
                    en_a_c = 1'b0;
                    en_b_c = 1'b0;
                end
            endcase
        end
        if (en_a_c || en_b_c) begin
            retired_d = retired_q + COUNT_W'(1);
        end
    end

    write_back_ffd #(.W($bits(reg_word_t))) u_reg_a (
        .clk_i (Clock),
        .rst_i (Reset),
        .en_i  (en_a_c),
        .d_i   (a_d),
        .q_o   (a_q)
    );

    write_back_ffd #(.W($bits(reg_word_t))) u_reg_b (
        .clk_i (Clock),
        .rst_i (Reset),
        .en_i  (en_b_c),
        .d_i   (b_d),
        .q_o   (b_q)
    );

    // Retired-operation counter; wraps silently, reset discards the same-cycle opcode.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign oReg_A   = a_q.data;
    assign oReg_B   = b_q.data;
    assign oCarryA  = a_q.carry;
    assign oCarryB  = b_q.carry;
    assign oZeroA   = (a_q.data == '0);
    assign oZeroB   = (b_q.data == '0);
    assign oRetired = retired_q;

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: driver pushes model predictions, monitor pops and compares.
module tb_write_back;
    import write_back_pkg::*;

    localparam int unsigned CW = 4;
    localparam int          CNT_MOD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [9:0]    data;
    logic [7:0]    res;
    logic          car;
    logic          stall;
    logic [7:0]    reg_a, reg_b;
    logic          carry_a, carry_b, zero_a, zero_b;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    write_back #(.COUNT_W(CW)) dut (
        .Clock          (clk),
        .Reset          (rst),
        .iOperation_EXC (op),
        .iData_EXC      (data),
        .iResult        (res),
        .iCarry         (car),
        .iStall         (stall),
        .oReg_A         (reg_a),
        .oReg_B         (reg_b),
        .oCarryA        (carry_a),
        .oCarryB        (carry_b),
        .oZeroA         (zero_a),
        .oZeroB         (zero_b),
        .oRetired       (retired)
    );

    typedef struct {
        int a;
        int b;
        int ca;
        int cb;
        int ret;
    } exp_t;

    exp_t exp_q[$];
    int   m_a, m_b, m_ca, m_cb, m_ret;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    // Reference model: architectural effect of one clock edge, from the opcode lists.
    task automatic model_step(input logic r, input logic [5:0] o, input logic [9:0] d,
                              input logic [7:0] rs, input logic c, input logic s);
        if (r) begin
            m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_ret = 0;
        end else if (!s) begin
            if (o inside {ADDA, ADDCA, SUBA, SUBCA, ANDA, ANDCA, ORA, ORCA, ASLA, ASRA}) begin
                m_a = rs; m_ca = c; m_ret = (m_ret + 1) % CNT_MOD;
            end else if (o inside {ADDB, ADDCB, SUBB, SUBCB, ANDB, ANDCB, ORB, ORCB}) begin
                m_b = rs; m_cb = c; m_ret = (m_ret + 1) % CNT_MOD;
            end else if (o == LDA) begin
                m_a = d % 256; m_ret = (m_ret + 1) % CNT_MOD;
            end else if (o == LDB) begin
                m_b = d % 256; m_ret = (m_ret + 1) % CNT_MOD;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the following edge.
    task automatic cycle(input logic r, input logic [5:0] o, input logic [9:0] d,
                         input logic [7:0] rs, input logic c, input logic s);
        exp_t e;
        @(negedge clk);
        rst = r; op = o; data = d; res = rs; car = c; stall = s;
        model_step(r, o, d, rs, c, s);
        e.a = m_a; e.b = m_b; e.ca = m_ca; e.cb = m_cb; e.ret = m_ret;
        exp_q.push_back(e);
    endtask

    // Wait for the edge that applies the last driven cycle, then allow a directed check.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge presents a new architectural state; compare against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("reg_a",   int'(reg_a),   e.a);
                cmp("reg_b",   int'(reg_b),   e.b);
                cmp("carry_a", int'(carry_a), e.ca);
                cmp("carry_b", int'(carry_b), e.cb);
                cmp("zero_a",  int'(zero_a),  (e.a == 0) ? 1 : 0);
                cmp("zero_b",  int'(zero_b),  (e.b == 0) ? 1 : 0);
                cmp("retired", int'(retired), e.ret);
            end
        end
    end

    initial begin
        int hold_a, hold_ret;
        logic [5:0] rop;
        rst = 1'b1; op = NOP; data = '0; res = '0; car = 1'b0; stall = 1'b0;
        m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_ret = 0;

        // Reset state with reset beating a stalled opcode.
        cycle(1'b1, ADDA, 10'h000, 8'h55, 1'b1, 1'b1);
        settle();
        cmp("reset_zero_a", int'(zero_a), 1);
        cmp("reset_zero_b", int'(zero_b), 1);

        // Loads.
        cycle(1'b0, LDA, 10'h0F5, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, LDB, 10'h00B, 8'h00, 1'b1, 1'b0);
        settle();
        cmp("ld_reg_a", int'(reg_a), 8'hF5);
        cmp("ld_reg_b", int'(reg_b), 8'h0B);
        cmp("ld_retired", int'(retired), 2);
        cmp("ld_carries", int'({carry_a, carry_b}), 0);

        // ADDA producing zero with carry.
        cycle(1'b0, ADDA, 10'h000, 8'h00, 1'b1, 1'b0);
        settle();
        cmp("adda_zero", int'(zero_a), 1);
        cmp("adda_carry", int'(carry_a), 1);
        cmp("adda_b_kept", int'(reg_b), 8'h0B);

        // SUBB held by a 3-cycle stall, then released.
        repeat (3) cycle(1'b0, SUBB, 10'h000, 8'h80, 1'b1, 1'b1);
        settle();
        cmp("stall_b_kept", int'(reg_b), 8'h0B);
        hold_ret = int'(retired);
        cycle(1'b0, SUBB, 10'h000, 8'h80, 1'b1, 1'b0);
        settle();
        cmp("subb_reg_b", int'(reg_b), 8'h80);
        cmp("subb_carry_b", int'(carry_b), 1);
        cmp("subb_retired", int'(retired), (hold_ret + 1) % CNT_MOD);

        // Undefined opcode and NOP for four cycles each.
        hold_ret = int'(retired);
        repeat (4) cycle(1'b0, 6'h3F, 10'h3FF, 8'hAA, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, NOP, 10'h3FF, 8'hAA, 1'b1, 1'b0);
        settle();
        cmp("undef_retired", int'(retired), hold_ret);

        // Counter wrap: sixteen ADDCA after reset reach 15 then 0.
        cycle(1'b1, NOP, 10'h000, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, ADDCA, 10'h000, 8'(i + 1), 1'(i % 2), 1'b0);
            if (i == 14) begin
                settle();
                cmp("wrap_at_15", int'(retired), 15);
            end
        end
        settle();
        cmp("wrap_to_0", int'(retired), 0);

        // Back-to-back dependent ADDA, no bubble.
        cycle(1'b0, ADDA, 10'h000, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, ADDA, 10'h000, 8'h22, 1'b0, 1'b0);
        settle();
        cmp("b2b_reg_a", int'(reg_a), 8'h22);

        // Reset in the same cycle as ORA 0xFF.
        cycle(1'b0, LDA, 10'h077, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, ORA, 10'h000, 8'hFF, 1'b1, 1'b0);
        settle();
        cmp("rst_ora_reg_a", int'(reg_a), 0);
        cmp("rst_ora_retired", int'(retired), 0);
        cycle(1'b0, LDB, 10'h1C3, 8'h00, 1'b0, 1'b0);
        settle();
        cmp("post_rst_retire", int'(retired), 1);
        hold_a = int'(reg_a);
        cmp("post_rst_a_kept", hold_a, 0);

        // Randomized traffic: mostly defined opcodes, some undefined, stalls and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) rop = 6'($urandom_range(0, 20));
            else                          rop = 6'($urandom_range(0, 63));
            cycle(1'($urandom_range(0, 39) == 0), rop, 10'($urandom),
                  8'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk);
        cmp("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
